// File: rtl/execute_stage.sv
// Execute stage of the RV64IM sequential core: ALU, branch resolution and control forwarding.
// Optional macro FAST_MUL_EN makes MUL single-cycle; otherwise MUL shares the iterative datapath with DIV/REM.
module execute_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DIV_ITERS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [3:0]      ALUOp,
  input  logic            ALUSrc,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [XLEN-1:0] Imm,
  input  logic            Branch,
  input  logic [2:0]      Funct3,
  input  logic [4:0]      Rd,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData,
  output logic            Zero,
  output logic            BranchTaken,
  output logic [4:0]      RdOut,
  output logic            MemReadOut,
  output logic            MemWriteOut,
  output logic            MemtoRegOut,
  output logic            RegWriteOut
);

  localparam int unsigned CW = $clog2(DIV_ITERS) + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_DIV  = 4'd11,
    OP_DIVU = 4'd12, OP_REM  = 4'd13, OP_REMU = 4'd14, OP_RSVD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e          r_state, w_state_nxt;
  alu_op_e         w_op, r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_dvs;
  logic            r_neg_q, r_neg_r, r_dvz;
  logic [XLEN-1:0] r_wd;
  logic            r_bt, r_mr, r_mw, r_m2r, r_rw;
  logic [4:0]      r_rd;

  logic [XLEN-1:0] w_opb, w_alu, w_a_mag, w_b_mag, w_mac, w_q, w_r, w_fin;
  logic [5:0]      w_shamt;
  logic            w_multi, w_signed, w_a_neg, w_b_neg, w_bt, w_ge, w_last, w_accept;
  logic [XLEN:0]   w_shift, w_trial;

  assign w_op     = alu_op_e'(ALUOp);
  assign w_opb    = ALUSrc ? Imm : ReadData2;
  assign w_shamt  = w_opb[5:0];
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(DIV_ITERS - 1));

`ifdef FAST_MUL_EN
  assign w_multi = (ALUOp >= 4'd11) && (ALUOp <= 4'd14);
`else
  assign w_multi = (ALUOp >= 4'd10) && (ALUOp <= 4'd14);
`endif

  always_comb begin
    w_alu = ReadData1 + w_opb;
    case (w_op)
      OP_SUB:  w_alu = ReadData1 - w_opb;
      OP_AND:  w_alu = ReadData1 & w_opb;
      OP_OR:   w_alu = ReadData1 | w_opb;
      OP_XOR:  w_alu = ReadData1 ^ w_opb;
      OP_SLL:  w_alu = ReadData1 << w_shamt;
      OP_SRL:  w_alu = ReadData1 >> w_shamt;
      OP_SRA:  w_alu = $signed(ReadData1) >>> w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(ReadData1) < $signed(w_opb))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (ReadData1 < w_opb)};
`ifdef FAST_MUL_EN
      OP_MUL:  w_alu = ReadData1 * w_opb;
`endif
      default: w_alu = ReadData1 + w_opb;
    endcase
  end

  // Branch compare always uses the register operands, never the immediate.
  always_comb begin
    w_bt = 1'b0;
    case (Funct3)
      3'b000:  w_bt = (ReadData1 == ReadData2);
      3'b001:  w_bt = (ReadData1 != ReadData2);
      3'b100:  w_bt = ($signed(ReadData1) <  $signed(ReadData2));
      3'b101:  w_bt = ($signed(ReadData1) >= $signed(ReadData2));
      3'b110:  w_bt = (ReadData1 <  ReadData2);
      3'b111:  w_bt = (ReadData1 >= ReadData2);
      default: w_bt = 1'b0;
    endcase
    w_bt = w_bt & Branch;
  end

  assign w_signed = (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg  = w_signed & ReadData1[XLEN-1];
  assign w_b_neg  = w_signed & w_opb[XLEN-1];
  assign w_a_mag  = w_a_neg ? -ReadData1 : ReadData1;
  assign w_b_mag  = w_b_neg ? -w_opb : w_opb;

  // Restoring divide step: r_rem is the partial remainder, dividend bits shift out of r_quo.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[XLEN];
  assign w_mac   = r_rem + (r_quo[0] ? r_dvs : '0);

  // Divide-by-zero overrides the sign fix-up so a negative dividend still yields all ones.
  assign w_q = r_dvz ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_r = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    case (r_op)
      OP_MUL:          w_fin = r_rem;
      OP_DIV, OP_DIVU: w_fin = w_q;
      default:         w_fin = w_r;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid && w_multi) w_state_nxt = S_RUN;
      S_RUN:    if (w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      ALUResult   <= '0;
      WriteData   <= '0;
      Zero        <= 1'b0;
      BranchTaken <= 1'b0;
      RdOut       <= '0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      MemtoRegOut <= 1'b0;
      RegWriteOut <= 1'b0;
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dvz       <= 1'b0;
      r_wd        <= '0;
      r_bt        <= 1'b0;
      r_rd        <= '0;
      r_mr        <= 1'b0;
      r_mw        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rw        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_multi) begin
            busy    <= 1'b1;
            r_op    <= w_op;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dvz   <= (w_opb == '0);
            r_rem   <= '0;
            r_wd    <= ReadData2;
            r_bt    <= w_bt;
            r_rd    <= Rd;
            r_mr    <= MemRead;
            r_mw    <= MemWrite;
            r_m2r   <= MemtoReg;
            r_rw    <= RegWrite;
            if (w_op == OP_MUL) begin
              r_quo <= w_opb;
              r_dvs <= ReadData1;
            end else begin
              r_quo <= w_a_mag;
              r_dvs <= w_b_mag;
            end
          end else if (w_accept) begin
            out_valid   <= 1'b1;
            ALUResult   <= w_alu;
            Zero        <= (w_alu == '0);
            WriteData   <= ReadData2;
            BranchTaken <= w_bt;
            RdOut       <= Rd;
            MemReadOut  <= MemRead;
            MemWriteOut <= MemWrite;
            MemtoRegOut <= MemtoReg;
            RegWriteOut <= RegWrite;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_MUL) begin
            r_rem <= w_mac;
            r_quo <= r_quo >> 1;
            r_dvs <= r_dvs << 1;
          end else begin
            r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
          end
        end
        S_FINISH: begin
          busy        <= 1'b0;
          out_valid   <= 1'b1;
          ALUResult   <= w_fin;
          Zero        <= (w_fin == '0);
          WriteData   <= r_wd;
          BranchTaken <= r_bt;
          RdOut       <= r_rd;
          MemReadOut  <= r_mr;
          MemWriteOut <= r_mw;
          MemtoRegOut <= r_m2r;
          RegWriteOut <= r_rw;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
